bcd_digit_stepper: RTL and testbench
====================================

BCD_DIGIT_STEPPER -- requirements
Module: bcd_digit_stepper

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the binary input width in bits.
REQ-002 The block SHALL have parameter DIGITS, default 5, giving the number of BCD digits, with the constraint 10^DIGITS > 2^WIDTH and DIGITS <= 8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a binary result is offered on in_value.
REQ-006 The block SHALL have port in_value, input, WIDTH bits: an unsigned binary value, for example a square-root result.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a value this cycle.
REQ-008 The block SHALL have port step, input, 1 bit: a level button input; each rising edge advances the displayed digit.
REQ-009 The block SHALL have port digit, output, 4 bits: the BCD digit currently selected, for a downstream seven-segment decoder.
REQ-010 The block SHALL have port digit_idx, output, 3 bits: the position of the selected digit, 0 = least significant.
REQ-011 The block SHALL have port digit_valid, output, 1 bit: digit and digit_idx hold a finished conversion.
REQ-012 The block SHALL have port digit_blank, output, 1 bit: the selected digit is a leading zero.
REQ-013 The block SHALL have port busy, output, 1 bit: a conversion is in progress.

Function
REQ-014 The block SHALL implement the states IDLE, SHIFT and SHOW.
REQ-015 In IDLE and SHOW, the block SHALL drive in_ready=1.
REQ-016 In IDLE and SHOW, on in_valid=1 the block SHALL load in_value, clear the BCD accumulator, set the bit counter to WIDTH and enter SHIFT.
REQ-017 In SHIFT, the block SHALL drive in_ready=0 and busy=1, and SHALL ignore in_valid.
REQ-018 In SHIFT, every cycle the block SHALL add 3 to each BCD nibble whose value is >=5, then shift {bcd, bin} left by one bit and decrement the counter.
REQ-019 When the counter reaches 0, the block SHALL enter SHOW with digit_idx=DIGITS-1 and digit_valid=1.
REQ-020 Latency: if a value is accepted at edge k, the block SHALL have digit_valid=1 and final digits after edge k+WIDTH+1; busy SHALL be high for exactly WIDTH+1 cycles.
REQ-021 The block SHALL compute a step edge as step=1 while step_q=0, where step_q is a register updated every cycle in all states.
REQ-022 In SHOW, on a step edge the block SHALL decrement digit_idx, wrapping from 0 to DIGITS-1.
REQ-023 The block SHALL ignore step edges in IDLE and SHIFT.
REQ-024 In SHOW, if in_valid and a step edge occur in the same cycle, the new conversion SHALL win and digit_idx SHALL be unchanged until the conversion ends.
REQ-025 The block SHALL drive digit combinationally from the nibble of the BCD accumulator at digit_idx.
REQ-026 The block SHALL drive digit_blank=1 only if digit_valid=1, digit_idx>0 and every nibble at position >= digit_idx is 0.
REQ-027 The block SHALL keep digit position 0 never blank, so a value of 0 displays as "0".
REQ-028 The block SHALL drive digit_valid=0 in IDLE and SHIFT.
REQ-029 During SHIFT, the block SHALL drive digit=0 and digit_blank=0.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force state=IDLE, accumulator=0, counter=0, digit_idx=0, step_q=0, digit_valid=0, busy=0, in_ready=1, digit=0 and digit_blank=0.
REQ-031 If reset is asserted mid-conversion, the block SHALL abort the conversion with no partial digits retained.
REQ-032 After release of reset, the block SHALL not treat step held high as an edge until step has been seen low.

Structure
REQ-033 The shared package SHALL hold the state encoding (IDLE=0, SHIFT=1, SHOW=2), the add-3 threshold constant 5, and the BCD nibble width 4.
REQ-034 The design SHALL use one sub-module, bcd_add3: a 4-bit combinational correction, instantiated DIGITS times.
REQ-035 The control FSM, counter and step edge detector SHALL reside in bcd_digit_stepper.

Verification
REQ-036 The bench SHALL check: in_value=1234 -> after 17 cycles, digit_idx=4, digit=0, digit_blank=1; steps then give idx3..0 = 1, 2, 3, 4, all with blank=0.
REQ-037 The bench SHALL check: in_value=65535 -> digits from idx4 to idx0 are 6, 5, 5, 3, 5; a sixth step wraps to idx4 with digit 6.
REQ-038 The bench SHALL check: in_value=0 -> idx4..1 have blank=1, and idx0 has digit 0 with blank=0.
REQ-039 The bench SHALL check: in_valid=1 with in_value=99 during SHIFT of 1234 -> ignored; the result is 1234; in_ready=0 throughout SHIFT.
REQ-040 The bench SHALL check: in_valid=1 with in_value=7 and a step edge in the same SHOW cycle -> conversion restarts; after 17 cycles idx=4 and digits read 0, 0, 0, 0, 7.
REQ-041 The bench SHALL check: rst_n pulsed low at cycle 5 of SHIFT -> outputs go to reset values at once; step held high across release produces no advance.

Source files
------------

// File: rtl/bcd_digit_stepper_pkg.sv
// Shared definitions for the BCD digit stepper.
//   state_t      : control FSM state encoding
//   NIBBLE_W     : bits per BCD digit
//   ADD3_THRESH  : nibble value at or above which double-dabble adds 3
//   add3_correct : the per-nibble correction applied before each shift
package bcd_digit_stepper_pkg;

  localparam int unsigned NIBBLE_W    = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SHOW  = 2'd2
  } state_t;

  function automatic logic [3:0] add3_correct(input logic [3:0] nibble);
    return (nibble >= ADD3_THRESH) ? nibble + 4'd3 : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit_stepper_add3.sv
// Combinational double-dabble nibble correction.
//   value     : current BCD nibble
//   corrected : value + 3 when value >= 5, otherwise value unchanged
module bcd_add3
  import bcd_digit_stepper_pkg::*;
(
  input  logic [3:0] value,
  output logic [3:0] corrected
);

  always_comb begin
    corrected = add3_correct(value);
  end

endmodule

// File: rtl/bcd_digit_stepper.sv
// Serial binary-to-BCD converter (double dabble) with a digit stepper for a
// single seven-segment display. A value accepted on in_valid is converted one
// bit per cycle; afterwards the most significant digit is shown and each
// rising edge of the step button moves one position towards the LSD,
// wrapping back to the MSD.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : binary value offered on in_value
//   in_value     : unsigned binary value (WIDTH bits)
//   in_ready     : a value can be accepted this cycle (low while converting)
//   step         : level button; each rising edge advances the digit
//   digit        : selected BCD digit (0 unless a result is shown)
//   digit_idx    : selected position, 0 = least significant
//   digit_valid  : digit/digit_idx hold a finished conversion
//   digit_blank  : selected digit is a leading zero (never position 0)
//   busy         : conversion in progress
module bcd_digit_stepper
  import bcd_digit_stepper_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic             in_ready,
  input  logic             step,
  output logic [3:0]       digit,
  output logic [2:0]       digit_idx,
  output logic             digit_valid,
  output logic             digit_blank,
  output logic             busy
);

  localparam int unsigned BCD_W    = DIGITS * NIBBLE_W;
  localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
  localparam logic [2:0]  LAST_IDX = 3'(DIGITS - 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   bin, bin_nx;
  logic [BCD_W-1:0]   bcd, bcd_nx, bcd_corr;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [2:0]         idx, idx_nx;
  logic               step_q;
  logic               armed, armed_nx;
  logic               step_edge;
  logic [3:0]         digit_sel;
  logic               nonzero_above;

  // One correction unit per BCD digit, all working on the current accumulator.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .value     (bcd[g*NIBBLE_W +: NIBBLE_W]),
      .corrected (bcd_corr[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  // armed only becomes set once step has been sampled low, so a button held
  // through reset release cannot register as a press.
  assign armed_nx  = armed | ~step;
  assign step_edge = step & ~step_q & armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bin    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      idx    <= '0;
      step_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      state  <= state_nx;
      bin    <= bin_nx;
      bcd    <= bcd_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      step_q <= step;
      armed  <= armed_nx;
    end
  end

  // The counter is loaded with WIDTH and the final SHIFT cycle (cnt == 0)
  // performs no shift; it only moves to SHOW. That extra cycle gives the
  // WIDTH+1 cycle busy window.
  always_comb begin
    state_nx = state;
    bin_nx   = bin;
    bcd_nx   = bcd;
    cnt_nx   = cnt;
    idx_nx   = idx;

    case (state)
      IDLE, SHOW: begin
        if (in_valid) begin
          // A new conversion wins over a simultaneous step; idx is held.
          bin_nx   = in_value;
          bcd_nx   = '0;
          cnt_nx   = CNT_W'(WIDTH);
          state_nx = SHIFT;
        end else if (state == SHOW && step_edge) begin
          idx_nx = (idx == 3'd0) ? LAST_IDX : idx - 3'd1;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          state_nx = SHOW;
          idx_nx   = LAST_IDX;
        end else begin
          {bcd_nx, bin_nx} = {bcd_corr, bin} << 1;
          cnt_nx           = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready    = (state != SHIFT);
    busy        = (state == SHIFT);
    digit_valid = (state == SHOW);
  end

  // Digit mux and leading-zero detection over positions >= idx.
  always_comb begin
    digit_sel     = '0;
    nonzero_above = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (3'(i) == idx) begin
        digit_sel = bcd[i*NIBBLE_W +: NIBBLE_W];
      end
      if (i >= 32'(idx) && bcd[i*NIBBLE_W +: NIBBLE_W] != '0) begin
        nonzero_above = 1'b1;
      end
    end
  end

  always_comb begin
    digit_idx   = idx;
    digit       = digit_valid ? digit_sel : 4'd0;
    digit_blank = digit_valid && (idx != 3'd0) && !nonzero_above;
  end

endmodule

// File: tb/tb_bcd_digit_stepper.sv
// Scoreboard bench for bcd_digit_stepper: expected digits are computed from
// the decimal value when a conversion is started and compared as the display
// is stepped through.
module tb_bcd_digit_stepper;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DIGITS = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_value;
  logic             in_ready;
  logic             step;
  logic [3:0]       digit;
  logic [2:0]       digit_idx;
  logic             digit_valid;
  logic             digit_blank;
  logic             busy;

  bcd_digit_stepper #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_value    (in_value),
    .in_ready    (in_ready),
    .step        (step),
    .digit       (digit),
    .digit_idx   (digit_idx),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] dig;
    logic       blank;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  function automatic exp_t model(input int unsigned v, input int unsigned pos);
    exp_t        e;
    int unsigned p = 1;
    for (int unsigned k = 0; k < pos; k++) p = p * 10;
    e.idx   = 3'(pos);
    e.dig   = 4'((v / p) % 10);
    e.blank = (pos != 0) && (v < p);
    return e;
  endfunction

  // Expected display sequence: MSD first, then one entry per step, wrapping.
  task automatic push_sequence(input int unsigned v, input int unsigned n);
    int unsigned pos = DIGITS - 1;
    for (int unsigned k = 0; k < n; k++) begin
      exp_q.push_back(model(v, pos));
      pos = (pos == 0) ? DIGITS - 1 : pos - 1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},  32'(busy),        32'd0);
    check_eq({tag, "_ready"}, 32'(in_ready),    32'd1);
    check_eq({tag, "_valid"}, 32'(digit_valid), 32'd0);
    check_eq({tag, "_digit"}, 32'(digit),       32'd0);
    check_eq({tag, "_blank"}, 32'(digit_blank), 32'd0);
    check_eq({tag, "_idx"},   32'(digit_idx),   32'd0);
  endtask

  // Waits (bounded) for in_ready, then presents v for one edge. Returns at
  // the falling edge after the accepting edge.
  task automatic accept(input logic [WIDTH-1:0] v);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check_eq("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_value = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts busy cycles from the first busy falling edge; optionally offers
  // a stray value mid-conversion and/or watches that digit_idx is held.
  task automatic busy_wait(input string tag, input bit inject, input bit watch,
                           input logic [2:0] hold_idx);
    int cycles    = 0;
    bit ready_bad = 0;
    bit show_bad  = 0;
    bit idx_bad   = 0;
    while (busy && cycles < 40) begin
      if (in_ready) ready_bad = 1;
      if (digit_valid || digit != 4'd0 || digit_blank) show_bad = 1;
      if (watch && digit_idx != hold_idx) idx_bad = 1;
      in_valid = inject && (cycles == 3);
      in_value = 16'd99;
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    check_eq({tag, "_busy_cycles"}, 32'(cycles), 32'(WIDTH + 1));
    check_eq({tag, "_ready_low"},   32'(ready_bad), 32'd0);
    check_eq({tag, "_shift_quiet"}, 32'(show_bad), 32'd0);
    if (watch) check_eq({tag, "_idx_held"}, 32'(idx_bad), 32'd0);
    check_eq({tag, "_done_valid"},  32'(digit_valid), 32'd1);
  endtask

  task automatic do_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  task automatic show_check(input string tag, input int unsigned n);
    exp_t e;
    for (int unsigned k = 0; k < n; k++) begin
      if (k > 0) do_step();
      if (exp_q.size() == 0) begin
        check_eq({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq($sformatf("%s_s%0d_idx", tag, k),   32'(digit_idx),   32'(e.idx));
        check_eq($sformatf("%s_s%0d_digit", tag, k), 32'(digit),       32'(e.dig));
        check_eq($sformatf("%s_s%0d_blank", tag, k), 32'(digit_blank), 32'(e.blank));
        check_eq($sformatf("%s_s%0d_valid", tag, k), 32'(digit_valid), 32'd1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    step     = 1'b0;
    #12;
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1234: MSD is a blank leading zero, then 1,2,3,4.
    push_sequence(1234, 5);
    accept(16'd1234);
    busy_wait("c1234", 1'b0, 1'b0, 3'd0);
    show_check("c1234", 5);

    // 65535 with a sixth step wrapping back to the MSD.
    push_sequence(65535, 6);
    accept(16'd65535);
    busy_wait("cmax", 1'b0, 1'b0, 3'd0);
    show_check("cmax", 6);

    // Zero: all blank except position 0.
    push_sequence(0, 5);
    accept(16'd0);
    busy_wait("czero", 1'b0, 1'b0, 3'd0);
    show_check("czero", 5);

    // A value offered during SHIFT is ignored.
    push_sequence(1234, 5);
    accept(16'd1234);
    busy_wait("cinj", 1'b1, 1'b0, 3'd0);
    show_check("cinj", 5);

    // New conversion and step edge in the same SHOW cycle: conversion wins.
    accept(16'd1234);
    busy_wait("cpre", 1'b0, 1'b0, 3'd0);
    do_step();
    check_eq("race_pre_idx", 32'(digit_idx), 32'd3);
    in_valid = 1'b1;
    in_value = 16'd7;
    step     = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    step     = 1'b0;
    push_sequence(7, 5);
    busy_wait("crace", 1'b0, 1'b1, 3'd3);
    show_check("crace", 5);

    // Reset in the fifth SHIFT cycle, with step held high across release.
    accept(16'd1234);
    repeat (4) @(negedge clk);
    check_eq("abort_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    step  = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    accept(16'd42);
    busy_wait("c42", 1'b0, 1'b0, 3'd0);
    repeat (3) @(negedge clk);
    check_eq("held_step_idx",   32'(digit_idx),   32'd4);
    check_eq("held_step_blank", 32'(digit_blank), 32'd1);
    step = 1'b0;
    @(negedge clk);
    push_sequence(42, 5);
    void'(exp_q.pop_front());
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    show_check("c42", 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
